// File: rtl/mul_issue_ctrl.sv
// Multi-cycle issue/capture controller around the combinational 32x32 multiplier.
// Optional MUL_ZERO_BYPASS_EN: zero operand skips the multiplier and finishes next edge.
module mul_issue_ctrl #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [32:0]      mul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      data_q, data_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic             zero_op;
    logic             unused_res_msb;

    assign unused_res_msb = mul_result[32];

    assign req_ready = rst_n & ~flush &
                       ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept    = req_valid & req_ready;

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_op = (req_a == 32'd0) | (req_b == 32'd0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        tag_d   = tag_q;
        unique case (state_q)
            IDLE: ;
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    data_d  = mul_result[31:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            tag_d = req_tag;
            if (zero_op) begin
                // Multiplier inputs left untouched to avoid toggling
                data_d  = 32'd0;
                cnt_d   = 4'd0;
                state_d = DONE;
            end else begin
                a_d     = req_a;
                b_d     = req_b;
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
        end
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            data_d  = data_q;
        end
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            data_q  <= 32'd0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign out_data  = data_q;
    assign out_tag   = tag_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a result scoreboard and a
// behavioural multiplier driving mul_result from mul_a/mul_b.
module tb_mul_issue_ctrl;

    localparam int TAG_W = 5;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             flush = 1'b0;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic [32:0]      mul_result;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   n_rx = 0;
    int   n_push = 0;

`ifdef MUL_ZERO_BYPASS_EN
    localparam int BYP_LAT = 1;
`else
    localparam int BYP_LAT = 3;
`endif

    mul_issue_ctrl #(.MUL_CYCLES(2), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .flush(flush),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier; bit 32 is a genuine product bit the DUT must drop
    logic [63:0] full_prod;
    assign full_prod  = 64'(mul_a) * 64'(mul_b);
    assign mul_result = full_prod[32:0];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (flush && busy) begin
                if (q.size() > 0) void'(q.pop_front());
            end else if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $error("FAIL sb_unexpected observed=%0h expected=none",
                           out_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_data", out_data, e.data);
                    chk("sb_tag", out_tag, e.tag);
                    n_rx++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t);
        exp_t e;
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        e.data = p[31:0];
        e.tag  = t;
        q.push_back(e);
        n_push++;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_tag = t;
        step();
        req_valid = 1'b0;
    endtask

    // Edges counted from the accepting edge (which counts as 1)
    task automatic wait_valid(input int exp_lat, input string tag);
        int n;
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk(tag, n, exp_lat);
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready", req_ready, 1);

        issue(32'd3, 32'd5, 5'd7);
        chk("acc_busy", busy, 1);
        chk("acc_valid", out_valid, 0);
        chk("acc_mul_a", mul_a, 3);
        chk("acc_mul_b", mul_b, 5);
        wait_valid(3, "lat_3x5");
        chk("d_3x5", out_data, 15);
        chk("t_3x5", out_tag, 7);
        chk("done_ready", req_ready, 1);
        step();
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
        chk("idle_ready", req_ready, 1);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        wait_valid(3, "lat_ff");
        chk("d_ff", out_data, 32'h1);
        step();
        issue(32'h0001_0000, 32'h0001_0000, 5'd2);
        wait_valid(3, "lat_1616");
        chk("d_1616", out_data, 32'h0);
        step();

        out_ready = 1'b0;
        issue(32'd4, 32'd11, 5'd3);
        wait_valid(3, "lat_hold");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, 44);
            chk("hold_tag", out_tag, 3);
            chk("hold_ready", req_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("b2b_ready", req_ready, 1);
        issue(32'd2, 32'd9, 5'd9);
        chk("b2b_busy", busy, 1);
        chk("b2b_valid", out_valid, 0);
        chk("b2b_mul_a", mul_a, 2);
        wait_valid(3, "lat_b2b");
        chk("d_b2b", out_data, 18);
        step();

        issue(32'd8, 32'd8, 5'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fw_busy", busy, 0);
        chk("fw_mul_a", mul_a, 8);
        chk("fw_data", out_data, 18);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        chk("fw_never_valid", seen, 0);

        out_ready = 1'b0;
        issue(32'd5, 32'd5, 5'd2);
        wait_valid(3, "lat_fd");
        flush = 1'b1;
        out_ready = 1'b1;
        req_valid = 1'b1;
        req_a = 32'd100;
        req_b = 32'd3;
        #1;
        chk("fd_ready", req_ready, 0);
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        chk("fd_valid", out_valid, 0);
        chk("fd_busy", busy, 0);
        chk("fd_mul_a", mul_a, 5);
        chk("fd_data", out_data, 25);
        step();

        issue(32'd6, 32'd6, 5'd4);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_valid", out_valid, 0);
        chk("mr_mul_a", mul_a, 0);
        chk("mr_data", out_data, 0);
        chk("mr_tag", out_tag, 0);
        chk("mr_ready", req_ready, 0);
        step();
        rst_n = 1'b1;
        issue(32'd6, 32'd7, 5'd12);
        wait_valid(3, "lat_6x7");
        chk("d_6x7", out_data, 42);
        step();

        issue(32'd0, 32'h1234, 5'd5);
        wait_valid(BYP_LAT, "lat_zero");
        chk("d_zero", out_data, 0);
`ifdef MUL_ZERO_BYPASS_EN
        chk("byp_mul_a", mul_a, 6);
        chk("byp_mul_b", mul_b, 7);
`else
        chk("byp_mul_a", mul_a, 0);
        chk("byp_mul_b", mul_b, 32'h1234);
`endif
        repeat (3) step();

        chk("sb_left", q.size(), 0);
        chk("sb_count", n_rx, n_push - 3);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Multi-cycle issue/capture controller placed directly around the combinational 32x32 Multiplier in the EX stage.
- Accepts a multiply request from the pipeline over a valid/ready handshake and registers the operands.
- Holds the operands stable on the Multiplier inputs for MUL_CYCLES clocks, which is its multicycle timing path.
- Captures the low 32 product bits and presents them, with the destination tag, to writeback over a valid/ready handshake.

Parameters:
- MUL_CYCLES, 2, clocks the Multiplier path is given; legal range 1..15.
- TAG_W, 5, width of the destination-register tag carried alongside the operation.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_a  input  32  multiplicand.
- req_b  input  32  multiplier.
- req_tag  input  TAG_W  destination tag.
- flush  input  1  pipeline flush; aborts any in-flight operation.
- mul_a  output  32  to Multiplier A (registered).
- mul_b  output  32  to Multiplier B (registered).
- mul_result  input  33  from Multiplier Result; bit 32 is ignored.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  product bits [31:0].
- out_tag  output  TAG_W  tag of the result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, WAIT, DONE. Countdown counter cnt is 4 bits.
- Reset (asynchronous, rst_n=0) sets:
  - state=IDLE, cnt=0;
  - mul_a, mul_b, out_data = 0 and out_tag = 0;
  - out_valid=0, busy=0.
  - req_ready is 0 while rst_n=0 and 1 in the first cycle after release.
- req_ready = !flush & (state==IDLE | (state==DONE & out_ready)). It is combinational.
- Accept occurs when req_valid & req_ready at a rising edge. On accept:
  - mul_a<=req_a, mul_b<=req_b, tag<=req_tag;
  - cnt<=MUL_CYCLES-1;
  - state<=WAIT.
- WAIT:
  - If cnt==0: out_data<=mul_result[31:0], state<=DONE.
  - Otherwise cnt<=cnt-1.
  - mul_a and mul_b never change while in WAIT.
- Latency: out_valid rises exactly MUL_CYCLES+1 edges after the accepting edge. The operands are therefore stable for MUL_CYCLES full cycles before capture.
- DONE:
  - out_valid=1; out_data and out_tag are held until out_ready=1.
  - out_ready without a new accept: state<=IDLE.
  - out_ready with a simultaneous accept (back-to-back): the new operands load and state<=WAIT with no idle bubble.
- out_valid is asserted only in DONE. out_tag reflects the registered tag.
- mul_a and mul_b retain their last values in IDLE, so the Multiplier inputs do not toggle.
- flush, from any state, at the next edge:
  - state<=IDLE, cnt<=0;
  - no accept occurs that cycle;
  - out_valid falls and a pending result is dropped;
  - out_data, mul_a and mul_b keep their values.
- flush has priority over every other event, including out_ready and req_valid in the same cycle.
- Arithmetic is unsigned modulo 2^32, which matches RV32M MUL (the low 32 bits are sign-agnostic).
- A reset asserted mid-operation returns to the reset values immediately and asynchronously.

Optional Feature:
- Macro MUL_ZERO_BYPASS_EN.
- Defined: on accept, if req_a==0 or req_b==0:
  - out_data<=0 and state<=DONE directly;
  - out_valid rises 1 edge after accept, with cnt unused;
  - mul_a and mul_b are NOT updated, which saves toggle power.
- Undefined: all operations take the full MUL_CYCLES+1 latency.

Test Plan:
- Reset then accept a=3, b=5, tag=7 with MUL_CYCLES=2, out_ready=1 -> out_valid high exactly 3 edges after accept with out_data=15, out_tag=7; then IDLE and req_ready=1.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> out_data=0x00000001. Also a=0x00010000, b=0x00010000 -> out_data=0x00000000.
- Result held with out_ready=0 for 5 cycles -> out_valid, out_data and out_tag stable, req_ready=0. Raising out_ready together with req_valid (a=2, b=9) -> back-to-back accept and next out_data=18.
- flush asserted on the first WAIT cycle -> IDLE next edge, out_valid never rises. flush held in DONE together with out_ready=1 and req_valid=1 -> no accept, out_valid=0.
- rst_n pulsed low during WAIT -> outputs zero immediately; after release a=6, b=7 -> 42 at the normal latency.
- MUL_ZERO_BYPASS_EN defined, a=0, b=0x1234 -> out_valid 1 edge after accept, out_data=0, mul_a and mul_b unchanged. Undefined -> same operands take 3 edges.
